// File: rtl/pixel_downscale_writer_if.sv
// Pixel stream, write-observe and read-port bundle for
// pixel_downscale_writer (master drives stream and rd_addr).
interface pixel_downscale_writer_if #(
  parameter int PIXEL_SIZE = 16,
  parameter int AW         = 13
);
  logic                  frame_start;
  logic                  pixel_valid;
  logic [PIXEL_SIZE-1:0] pixel_data;
  logic [AW-1:0]         rd_addr;
  logic [PIXEL_SIZE-1:0] rd_data;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic                  frame_done;
  logic                  overrun;
  logic                  short_frame;

  modport master (
    output frame_start, pixel_valid, pixel_data, rd_addr,
    input  rd_data, wr_en, wr_addr, frame_done,
    input  overrun, short_frame
  );

  modport slave (
    input  frame_start, pixel_valid, pixel_data, rd_addr,
    output rd_data, wr_en, wr_addr, frame_done,
    output overrun, short_frame
  );
endinterface

// File: rtl/pixel_downscale_writer.sv
// Decimates a SRC_W x SRC_H raster by SCALE per axis into a frame buffer.
// Ports: clk_input_data, rst (sync, active-low), bus (slave modport).
module pixel_downscale_writer #(
  parameter int SRC_W      = 240,
  parameter int SRC_H      = 240,
  parameter int SCALE      = 3,
  parameter int PIXEL_SIZE = 16,
  localparam int DST_W     = SRC_W / SCALE,
  localparam int DST_H     = SRC_H / SCALE,
  localparam int DEPTH     = DST_W * DST_H,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic clk_input_data,
  input  logic rst,
  pixel_downscale_writer_if.slave bus
);

  localparam int CW = $clog2(SRC_W);
  localparam int RW = $clog2(SRC_H);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(SRC_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SRC_H - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;
  logic [SW-1:0] sub_c_q, sub_c_d, sub_c_c;
  logic [SW-1:0] sub_r_q, sub_r_d, sub_r_c;
  logic [AW-1:0] dst_c_q, dst_c_d, dst_c_c;
  logic [AW-1:0] lbase_q, lbase_d, lbase_c;

  logic          acc;
  logic          wr_d, wr_en_q;
  logic [AW-1:0] waddr_d, wr_addr_q;
  logic          ovr_d, ovr_q;
  logic          shrt_d, shrt_q;
  logic [PIXEL_SIZE-1:0] rd_data_q;

  logic [PIXEL_SIZE-1:0] mem [DEPTH];

  always_comb begin
    // frame_start makes this cycle's pixel pixel 0 of a new frame
    col_c   = bus.frame_start ? '0 : col_q;
    row_c   = bus.frame_start ? '0 : row_q;
    sub_c_c = bus.frame_start ? '0 : sub_c_q;
    sub_r_c = bus.frame_start ? '0 : sub_r_q;
    dst_c_c = bus.frame_start ? '0 : dst_c_q;
    lbase_c = bus.frame_start ? '0 : lbase_q;

    acc = bus.pixel_valid &&
          (bus.frame_start || state_q == RECV);
    wr_d    = acc && sub_c_c == '0 && sub_r_c == '0;
    waddr_d = lbase_c + dst_c_c;

    col_d   = col_c;
    row_d   = row_c;
    sub_c_d = sub_c_c;
    sub_r_d = sub_r_c;
    dst_c_d = dst_c_c;
    lbase_d = lbase_c;

    if (acc) begin
      if (col_c == COL_LAST) begin
        col_d   = '0;
        sub_c_d = '0;
        dst_c_d = '0;
        if (row_c == ROW_LAST) begin
          row_d   = '0;
          sub_r_d = '0;
          lbase_d = '0;
        end else begin
          row_d = row_c + RW'(1);
          if (sub_r_c == SUB_LAST) begin
            sub_r_d = '0;
            lbase_d = lbase_c + AW'(DST_W);
          end else begin
            sub_r_d = sub_r_c + SW'(1);
          end
        end
      end else begin
        col_d = col_c + CW'(1);
        if (sub_c_c == SUB_LAST) begin
          sub_c_d = '0;
          dst_c_d = dst_c_c + AW'(1);
        end else begin
          sub_c_d = sub_c_c + SW'(1);
        end
      end
    end

    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.frame_start) state_d = RECV;
      RECV: state_d = RECV;
      DONE: if (bus.frame_start) state_d = RECV;
      default: state_d = IDLE;
    endcase
    if (acc && col_c == COL_LAST && row_c == ROW_LAST)
      state_d = DONE;

    ovr_d  = ovr_q | (state_q == DONE && bus.pixel_valid &&
                      !bus.frame_start);
    shrt_d = shrt_q | (state_q == RECV && bus.frame_start);
  end

  always_ff @(posedge clk_input_data) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      sub_c_q   <= '0;
      sub_r_q   <= '0;
      dst_c_q   <= '0;
      lbase_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      ovr_q     <= 1'b0;
      shrt_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sub_c_q   <= sub_c_d;
      sub_r_q   <= sub_r_d;
      dst_c_q   <= dst_c_d;
      lbase_q   <= lbase_d;
      wr_en_q   <= wr_d;
      wr_addr_q <= wr_d ? waddr_d : wr_addr_q;
      ovr_q     <= ovr_d;
      shrt_q    <= shrt_d;
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  // Commits on the same edge that raises wr_en; a same-cycle read
  // of this address still returns the old word.
  always_ff @(posedge clk_input_data) begin
    if (rst && wr_d)
      mem[waddr_d] <= bus.pixel_data;
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.frame_done  = (state_q == DONE);
  assign bus.overrun     = ovr_q;
  assign bus.short_frame = shrt_q;

endmodule

// File: tb/tb_pixel_downscale_writer.sv
// Directed bench: full-size instance for the 240x240 frame, a 30x30
// instance for bubbles, short-frame and mid-frame reset scenarios.
module tb_pixel_downscale_writer;

  localparam int SN = 30;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pixel_downscale_writer_if #(.PIXEL_SIZE(16), .AW(13)) bif ();
  pixel_downscale_writer_if #(.PIXEL_SIZE(16), .AW(7))  sif ();

  pixel_downscale_writer u_big (
    .clk_input_data (clk),
    .rst            (rst),
    .bus            (bif)
  );

  pixel_downscale_writer #(
    .SRC_W (SN),
    .SRC_H (SN)
  ) u_small (
    .clk_input_data (clk),
    .rst            (rst),
    .bus            (sif)
  );

  int n_chk = 0;
  int n_err = 0;
  int bwr = 0;
  int swr = 0;
  int base;

  always @(posedge clk) begin
    if (bif.wr_en === 1'b1) bwr++;
    if (sif.wr_en === 1'b1) swr++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_b(input string tag, input logic [12:0] a,
                      input logic [15:0] e);
    bif.rd_addr = a;
    @(negedge clk);
    chk(tag, 32'(bif.rd_data), 32'(e));
  endtask

  task automatic rd_s(input string tag, input logic [6:0] a,
                      input logic [15:0] e);
    sif.rd_addr = a;
    @(negedge clk);
    chk(tag, 32'(sif.rd_data), 32'(e));
  endtask

  // Small-frame sender; pixel = {row,col} ^ key.
  task automatic send_s(input int npix, input bit bub,
                        input bit fs_first, input logic [15:0] key);
    if (!fs_first) begin
      sif.frame_start = 1'b1;
      sif.pixel_valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < npix; i++) begin
      if (bub)
        while ($urandom_range(0, 99) < 30) begin
          sif.frame_start = 1'b0;
          sif.pixel_valid = 1'b0;
          @(negedge clk);
        end
      sif.frame_start = fs_first && (i == 0);
      sif.pixel_valid = 1'b1;
      sif.pixel_data  = {8'(i / SN), 8'(i % SN)} ^ key;
      @(negedge clk);
    end
    sif.frame_start = 1'b0;
    sif.pixel_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bif.frame_start = 0; bif.pixel_valid = 0;
    bif.pixel_data = '0; bif.rd_addr = '0;
    sif.frame_start = 0; sif.pixel_valid = 0;
    sif.pixel_data = '0; sif.rd_addr = '0;
    repeat (3) @(negedge clk);

    chk("rst_rd_data", 32'(bif.rd_data), 0);
    chk("rst_wr_en", 32'(bif.wr_en), 0);
    chk("rst_wr_addr", 32'(bif.wr_addr), 0);
    chk("rst_done", 32'(bif.frame_done), 0);
    chk("rst_overrun", 32'(bif.overrun), 0);
    chk("rst_short", 32'(bif.short_frame), 0);
    chk("rst_s_done", 32'(sif.frame_done), 0);
    rst = 1'b1;

    // valid without frame_start in IDLE is ignored
    bif.pixel_valid = 1; bif.pixel_data = 16'h1234;
    sif.pixel_valid = 1; sif.pixel_data = 16'h1234;
    repeat (4) @(negedge clk);
    bif.pixel_valid = 0; sif.pixel_valid = 0;
    repeat (2) @(negedge clk);
    chk("idle_b_writes", 32'(bwr), 0);
    chk("idle_s_writes", 32'(swr), 0);
    chk("idle_overrun", 32'(bif.overrun), 0);
    chk("idle_done", 32'(bif.frame_done), 0);

    // full 240x240 frame, frame_start with pixel 0
    base = bwr;
    for (int r = 0; r < 240; r++)
      for (int c = 0; c < 240; c++) begin
        bif.frame_start = (r == 0 && c == 0);
        bif.pixel_valid = 1'b1;
        bif.pixel_data  = {8'(r), 8'(c)};
        if (r == 239 && c == 239)
          chk("done_early", 32'(bif.frame_done), 0);
        @(negedge clk);
      end
    bif.frame_start = 0; bif.pixel_valid = 0;
    chk("done_rise", 32'(bif.frame_done), 1);
    repeat (2) @(negedge clk);
    chk("full_writes", 32'(bwr - base), 6400);
    rd_b("rd_0", 13'd0, 16'h0000);
    rd_b("rd_81", 13'd81, 16'h0303);
    rd_b("rd_6399", 13'd6399, 16'hEDED);
    chk("done_hold", 32'(bif.frame_done), 1);

    // overrun after frame_done
    base = bwr;
    bif.pixel_valid = 1; bif.pixel_data = 16'hFFFF;
    repeat (5) @(negedge clk);
    bif.pixel_valid = 0;
    repeat (2) @(negedge clk);
    chk("ovr_flag", 32'(bif.overrun), 1);
    chk("ovr_writes", 32'(bwr - base), 0);
    rd_b("ovr_rd_6399", 13'd6399, 16'hEDED);
    chk("ovr_done", 32'(bif.frame_done), 1);
    chk("ovr_short", 32'(bif.short_frame), 0);

    // small continuous frame with key
    base = swr;
    send_s(SN * SN, 0, 1, 16'h5A5A);
    chk("s_done", 32'(sif.frame_done), 1);
    repeat (2) @(negedge clk);
    chk("s_writes", 32'(swr - base), 100);
    rd_s("s_rd_11", 7'd11, 16'h5959);
    rd_s("s_rd_99", 7'd99, 16'h4141);

    // bubbles, plain data overwrites keyed data
    base = swr;
    send_s(SN * SN, 1, 0, 16'h0000);
    repeat (2) @(negedge clk);
    chk("b_writes", 32'(swr - base), 100);
    chk("b_done", 32'(sif.frame_done), 1);
    rd_s("b_rd_0", 7'd0, 16'h0000);
    rd_s("b_rd_11", 7'd11, 16'h0303);
    rd_s("b_rd_55", 7'd55, 16'h0F0F);
    rd_s("b_rd_99", 7'd99, 16'h1B1B);

    // short frame then full frame
    chk("sh_before", 32'(sif.short_frame), 0);
    send_s(300, 0, 0, 16'h1111);
    chk("sh_mid_done", 32'(sif.frame_done), 0);
    base = swr;
    send_s(SN * SN, 0, 1, 16'h0000);
    repeat (2) @(negedge clk);
    chk("sh_flag", 32'(sif.short_frame), 1);
    chk("sh_writes", 32'(swr - base), 100);
    rd_s("sh_rd_0", 7'd0, 16'h0000);
    rd_s("sh_rd_11", 7'd11, 16'h0303);
    rd_s("sh_rd_99", 7'd99, 16'h1B1B);

    // mid-frame reset
    send_s(500, 0, 1, 16'h2222);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_done", 32'(sif.frame_done), 0);
    chk("mr_short", 32'(sif.short_frame), 0);
    base = swr;
    sif.pixel_valid = 1; sif.pixel_data = 16'hAAAA;
    repeat (3) @(negedge clk);
    sif.pixel_valid = 0;
    repeat (2) @(negedge clk);
    chk("mr_idle_writes", 32'(swr - base), 0);
    base = swr;
    send_s(SN * SN, 0, 0, 16'h0000);
    repeat (2) @(negedge clk);
    chk("mr_writes", 32'(swr - base), 100);
    chk("mr_done2", 32'(sif.frame_done), 1);
    rd_s("mr_rd_0", 7'd0, 16'h0000);
    rd_s("mr_rd_99", 7'd99, 16'h1B1B);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
